// File: rtl/efdr_encoder.sv
// EFDR run-length encoder.
// Counts runs of identical bits, including the first differing bit that ends
// the run, then emits each run as a serial codeword: the run type, a prefix
// of k-1 ones followed by a zero, and a k-bit tail.
// Runs are limited to 62 bits. A run that reaches that limit without a
// terminator is flushed and err_ovf is set; that flag is sticky until reset.
module efdr_encoder (
    input  logic clk,
    input  logic reset,
    input  logic in_bit,
    input  logic in_valid,
    input  logic in_last,
    output logic in_ready,
    input  logic en,
    output logic bit_out,
    output logic out_valid,
    output logic out_last,
    output logic err_ovf
);

    typedef enum logic [1:0] {
        COUNT       = 2'd0,
        EMIT_TYPE   = 2'd1,
        EMIT_PREFIX = 2'd2,
        EMIT_TAIL   = 2'd3
    } state_e;

    localparam logic [5:0] MAX_RUN = 6'd62;

    state_e      state_q, state_d;
    logic        live_q, live_d;     // low only for the cycle right after reset
    logic [5:0]  n_q, n_d;           // bits counted in the current run
    logic        t_q, t_d;           // run type
    logic        tset_q, tset_d;     // run type has been latched
    logic        cw_t_q, cw_t_d;     // latched codeword fields
    logic [2:0]  k_q, k_d;
    logic [4:0]  tail_q, tail_d;
    logic [2:0]  idx_q, idx_d;       // bit index within the prefix or tail
    logic        last_q, last_d;     // codeword closes the stream
    logic        err_q, err_d;

    // Run-closing decode on the accepted bit
    logic        accept;
    logic        term;
    logic [5:0]  n_inc;
    logic        hit_max;
    logic        close;
    logic [5:0]  m_close;
    logic [2:0]  k_close;
    logic [5:0]  pow_close;
    logic [5:0]  tail_close;
    logic [2:0]  k_last;
    logic [2:0]  tail_sel;
    logic [4:0]  tail_sh;

    // k = floor(log2 m) for m in 2..63
    always_comb begin
        m_close = n_inc + 6'd1;
        if (m_close[5])      k_close = 3'd5;
        else if (m_close[4]) k_close = 3'd4;
        else if (m_close[3]) k_close = 3'd3;
        else if (m_close[2]) k_close = 3'd2;
        else                 k_close = 3'd1;
        pow_close  = 6'd1 << k_close;
        tail_close = m_close - pow_close;
    end

    // Input acceptance and run-termination detection
    always_comb begin
        accept  = in_valid & in_ready;
        term    = tset_q & (in_bit != t_q);
        n_inc   = n_q + 6'd1;
        hit_max = (n_inc == MAX_RUN);
        close   = accept & (term | hit_max | in_last);
    end

    // Next-state logic for the counter and the emission sequencer
    always_comb begin
        state_d = state_q;
        live_d  = 1'b1;
        n_d     = n_q;
        t_d     = t_q;
        tset_d  = tset_q;
        cw_t_d  = cw_t_q;
        k_d     = k_q;
        tail_d  = tail_q;
        idx_d   = idx_q;
        last_d  = last_q;
        err_d   = err_q;
        k_last  = k_q - 3'd1;

        case (state_q)
            COUNT: begin
                if (accept) begin
                    if (!tset_q) begin
                        t_d    = in_bit;
                        tset_d = 1'b1;
                    end
                    n_d = n_inc;
                end
                if (close) begin
                    // A terminator already ends the run, so only an
                    // unterminated 62nd bit counts as an overflow.
                    if (hit_max && !term) err_d = 1'b1;
                    cw_t_d  = tset_q ? t_q : in_bit;
                    k_d     = k_close;
                    tail_d  = tail_close[4:0];
                    idx_d   = 3'd0;
                    last_d  = in_last;
                    n_d     = 6'd0;
                    tset_d  = 1'b0;
                    state_d = EMIT_TYPE;
                end
            end
            EMIT_TYPE: begin
                if (en) begin
                    idx_d   = 3'd0;
                    state_d = EMIT_PREFIX;
                end
            end
            EMIT_PREFIX: begin
                if (en) begin
                    if (idx_q == k_last) begin
                        idx_d   = 3'd0;
                        state_d = EMIT_TAIL;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            EMIT_TAIL: begin
                if (en) begin
                    if (idx_q == k_last) begin
                        idx_d   = 3'd0;
                        last_d  = 1'b0;
                        state_d = COUNT;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = COUNT;
        endcase
    end

    // Serial codeword output; the tail is sent MSB first
    always_comb begin
        in_ready  = live_q & (state_q == COUNT);
        out_valid = (state_q != COUNT);
        bit_out   = 1'b0;
        out_last  = 1'b0;
        tail_sel  = k_q - 3'd1 - idx_q;
        tail_sh   = tail_q >> tail_sel;
        case (state_q)
            EMIT_TYPE:   bit_out = cw_t_q;
            EMIT_PREFIX: bit_out = (idx_q != (k_q - 3'd1));
            EMIT_TAIL: begin
                bit_out  = tail_sh[0];
                out_last = last_q & (idx_q == (k_q - 3'd1));
            end
            default:     bit_out = 1'b0;
        endcase
        err_ovf = err_q;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= COUNT;
            live_q  <= 1'b0;
            n_q     <= 6'd0;
            t_q     <= 1'b0;
            tset_q  <= 1'b0;
            cw_t_q  <= 1'b0;
            k_q     <= 3'd1;
            tail_q  <= 5'd0;
            idx_q   <= 3'd0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= live_d;
            n_q     <= n_d;
            t_q     <= t_d;
            tset_q  <= tset_d;
            cw_t_q  <= cw_t_d;
            k_q     <= k_d;
            tail_q  <= tail_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_efdr_encoder.sv
// Scoreboard bench for efdr_encoder: accepted input bits feed a run-level
// reference model that queues expected codeword bits; an output monitor
// pops and compares on every out_valid & en transfer.
module tb_efdr_encoder;

    logic clk, reset, in_bit, in_valid, in_last, en;
    logic in_ready, bit_out, out_valid, out_last, err_ovf;

    efdr_encoder dut (
        .clk(clk), .reset(reset), .in_bit(in_bit), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .en(en), .bit_out(bit_out),
        .out_valid(out_valid), .out_last(out_last), .err_ovf(err_ovf)
    );

    typedef struct {
        bit b;
        bit l;
        bit e;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   close_cyc = -10;
    bit   en_rand = 0;

    // reference model state
    int   m_n = 0;
    bit   m_t = 0;
    bit   m_have = 0;
    bit   m_err = 0;

    bit   hold_chk = 0;
    bit   hold_bit = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Codeword for a run of n bits of type t, built from the arithmetic rule
    function automatic void push_codeword(input bit t, input int n, input bit last, input bit e);
        int   m, k, tail;
        exp_t x;
        m = n + 1;
        k = 0;
        while ((1 << (k + 1)) <= m) k++;
        tail = m - (1 << k);
        x.e = e; x.l = 0;
        x.b = t; exp_q.push_back(x);
        for (int i = 0; i < k; i++) begin
            x.b = (i < k - 1);
            exp_q.push_back(x);
        end
        for (int i = k - 1; i >= 0; i--) begin
            x.b = (tail >> i) & 1;
            x.l = last && (i == 0);
            exp_q.push_back(x);
        end
    endfunction

    function automatic void model_accept(input bit b, input bit last);
        bit term;
        term = 0;
        if (!m_have) begin
            m_have = 1;
            m_t = b;
            m_n = 1;
        end else begin
            m_n++;
            term = (b != m_t);
        end
        if (term || m_n == 62 || last) begin
            if (m_n == 62 && !term) m_err = 1;
            push_codeword(m_t, m_n, last, m_err);
            m_have = 0;
            m_n = 0;
            close_cyc = cyc;
        end
    endfunction

    // Input side: every accepted bit goes through the model
    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            m_have = 0;
            m_n = 0;
            m_err = 0;
            close_cyc = -10;
        end else if (in_valid && in_ready) begin
            model_accept(in_bit, in_last);
        end
    end

    // Output side: compare each transferred codeword bit
    always @(negedge clk) begin
        exp_t x;
        if (reset) begin
            if (hold_chk) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_bit", bit_out, hold_bit);
            end
            if (out_valid) chk("rdy_in_emit", in_ready, 0);
            if (cyc == close_cyc + 1) chk("latency", out_valid, 1);
            if (out_valid && en) begin
                if (exp_q.size() == 0) begin
                    chk("extra_bit", 1, 0);
                end else begin
                    x = exp_q.pop_front();
                    chk("bit_out", bit_out, x.b);
                    chk("out_last", out_last, x.l);
                    chk("err_ovf", err_ovf, x.e);
                end
            end
            hold_chk = out_valid && !en;
            hold_bit = bit_out;
        end else begin
            hold_chk = 0;
        end
    end

    // Downstream ready
    initial begin
        en = 1;
        forever begin
            @(posedge clk);
            #1;
            en = en_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send(input bit b, input bit l);
        int t;
        t = 0;
        in_valid = 1;
        in_bit = b;
        in_last = l;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 300) begin
                chk("accept_timeout", t, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 0;
        in_last = 0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) chk("idle_timeout", t, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        bit b, mode_long;
        reset = 0; in_valid = 0; in_bit = 0; in_last = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_bit_out", bit_out, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_err", err_ovf, 0);
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk);
        @(negedge clk);
        chk("rdy_after_rst", in_ready, 1);
        @(posedge clk); #1;

        // 1,1,1,0 -> 1,1,0,0,1
        send(1, 0); send(1, 0); send(1, 0); send(0, 0);
        wait_idle();
        // 0,1 then 1,0
        send(0, 0); send(1, 0);
        send(1, 0); send(0, 0);
        wait_idle();
        // 0,0 with in_last
        send(0, 0); send(0, 1);
        wait_idle();
        // 62 ones -> overflow, then a fresh run
        for (int i = 0; i < 62; i++) send(1, 0);
        send(0, 0); send(1, 0);
        wait_idle();
        chk("err_sticky", err_ovf, 1);
        // 1,1,1,0 with toggling en
        en_rand = 1;
        send(1, 0); send(1, 0); send(1, 0); send(0, 0);
        wait_idle();
        en_rand = 0;
        @(posedge clk); #1;

        // reset during the prefix of a codeword
        send(1, 0); send(1, 0); send(1, 0); send(0, 0);
        t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("emit_started", out_valid, 1);
        @(posedge clk); #1;        // type bit transferred, now in prefix
        reset = 0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_err", err_ovf, 0);
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;
        send(1, 0); send(0, 0);
        wait_idle();

        // randomized traffic, with occasional long runs to hit overflow
        en_rand = 1;
        mode_long = 0;
        b = 0;
        for (int i = 0; i < 1500; i++) begin
            if ((i % 100) == 0) mode_long = ($urandom_range(0, 2) == 0);
            if (mode_long) b = ($urandom_range(0, 40) == 0) ? ~b : b;
            else           b = 1'($urandom_range(0, 1));
            send(b, $urandom_range(0, 30) == 0);
            repeat ($urandom_range(0, 1)) begin
                @(posedge clk); #1;
            end
        end
        wait_idle();
        chk("drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/efdr_encoder.md
EFDR_ENCODER -- requirements
Module: efdr_encoder

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-002 SHALL have port reset  input  1  reset, synchronous, active-low (0 = reset, sampled on clk rising edge).
REQ-003 SHALL have port in_bit  input  1  raw test-data bit from the upstream source.
REQ-004 SHALL have port in_valid  input  1  in_bit valid this cycle.
REQ-005 SHALL have port in_last  input  1  qualifies in_bit as the final bit of the stream.
REQ-006 SHALL have port in_ready  output  1  encoder accepts a bit this cycle; transfer = in_valid & in_ready.
REQ-007 SHALL have port en  input  1  downstream EFDR decoder ready for the next codeword bit.
REQ-008 SHALL have port bit_out  output  1  serial EFDR codeword bit, drives the decoder's bit_in.
REQ-009 SHALL have port out_valid  output  1  bit_out valid; transfer = out_valid & en.
REQ-010 SHALL have port out_last  output  1  high with the final codeword bit of the stream.
REQ-011 SHALL have port err_ovf  output  1  sticky run-length overflow flag.

Function
REQ-012 SHALL define a run as: first bit sets type T; run continues while bit == T; the first bit != T is the terminator and belongs to the run; n = bit count incl. terminator (n >= 1).
REQ-013 SHALL encode with m = n+1, k = floor(log2 m) (k >= 1): codeword = T, then prefix (k-1 ones, then one 0), then tail = k bits of (m - 2^k), MSB first; length 2k+1.
REQ-014 SHALL support n <= 62 (m <= 63, k <= 5, codeword <= 11 bits); run counter 6 bits.
REQ-015 SHALL implement FSM states COUNT, EMIT_TYPE, EMIT_PREFIX, EMIT_TAIL.
REQ-016 In COUNT: in_ready = 1, out_valid = 0; each accepted bit increments n; the first bit of a run latches T.
REQ-017 COUNT -> EMIT_TYPE on the clock edge that accepts a terminator, the 62nd bit of a run, or any bit with in_last = 1.
REQ-018 In EMIT_*: in_ready = 0; out_valid = 1; state/bit index advance only on out_valid & en; bit_out and out_valid held stable while en = 0.
REQ-019 EMIT_TYPE -> EMIT_PREFIX -> EMIT_TAIL sequentially; the prefix emits k bits; the tail emits k bits; after the last tail-bit transfer -> COUNT with n = 0 and T unset.
REQ-020 Latency: first codeword bit (T) SHALL be valid the cycle after the closing bit is accepted; one codeword bit per cycle when en = 1.
REQ-021 in_last SHALL close the current run as if terminated (n includes that bit); out_last = 1 only on that codeword's final tail bit; afterwards the encoder returns to COUNT ready for a new stream.
REQ-022 When a run reaches 62 bits without a terminator, the encoder SHALL set err_ovf = 1, emit the codeword for n = 62, and start a fresh run with the next bit (lossy).
REQ-023 in_last coinciding with a terminator or the 62nd bit SHALL produce one codeword only (same n), out_last set; err_ovf still set in the 62nd-bit case.
REQ-024 err_ovf SHALL clear only on reset.

Reset
REQ-025 While reset = 0 at a clock edge: state = COUNT, n = 0, T unset, in_ready = 0, out_valid = 0, bit_out = 0, out_last = 0, err_ovf = 0.
REQ-026 in_ready SHALL go to 1 the first cycle after reset is sampled at 1.
REQ-027 Reset mid-emission SHALL abandon the codeword immediately; no partial bits are emitted after reset release.

Verification
REQ-028 Input 1,1,1,0 with en = 1 -> bit_out 1,1,0,0,1 (n=4, k=2), out_valid for exactly 5 cycles, first bit one cycle after the 0 is accepted.
REQ-029 Input 0,1 then 1,0 -> codewords 0,0,1 then 1,0,1 (n=2, k=1 each); in_ready low during each emission.
REQ-030 Input 1,1,1,0 with en toggling 1,0,0,1,... -> same 5-bit sequence, bit_out constant through en = 0 cycles, no bits duplicated or lost.
REQ-031 Input 0,0 with in_last on the second 0 -> 0,0,1 with out_last = 1 on the final bit only.
REQ-032 Input 62 ones -> err_ovf = 1, codeword 1,1,1,1,1,0,1,1,1,1,1 (n=62, k=5); the next bit starts a new run.
REQ-033 reset = 0 during the EMIT_PREFIX of a codeword -> next cycle out_valid = 0, err_ovf = 0; a subsequent 1,0 encodes as 1,0,1.
